instr_encoder: RTL



---
 rtl/instr_encoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Symbolic-to-MIPS instruction encoder that streams assembled words into IMem.
// Used by the boot/self-test loader to fill instruction memory before the pipeline starts.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FULL  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] BASE_PTR = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] TOP_PTR  = {ADDR_WIDTH{1'b1}};

    function automatic logic [31:0] r_fmt(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] funct);
        return {6'h00, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] i_fmt(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // Bit 32 flags a legal mnemonic; unused fields are forced to zero.
    function automatic logic [32:0] encode(input logic [4:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [15:0] imm,
                                           input logic [25:0] tgt);
        case (op)
            5'd0:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h20)};
            5'd1:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h21)};
            5'd2:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h22)};
            5'd3:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h23)};
            5'd4:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h24)};
            5'd5:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h25)};
            5'd6:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h26)};
            5'd7:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h27)};
            5'd8:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h2a)};
            5'd9:    return {1'b1, r_fmt(rs, rt, rd, 5'd0, 6'h2b)};
            5'd10:   return {1'b1, r_fmt(5'd0, rt, rd, sh, 6'h00)};
            5'd11:   return {1'b1, r_fmt(5'd0, rt, rd, sh, 6'h02)};
            5'd12:   return {1'b1, r_fmt(5'd0, rt, rd, sh, 6'h03)};
            5'd13:   return {1'b1, r_fmt(rs, 5'd0, 5'd0, 5'd0, 6'h08)};
            5'd14:   return {1'b1, r_fmt(rs, 5'd0, rd, 5'd0, 6'h09)};
            5'd15:   return {1'b1, i_fmt(6'h08, rs, rt, imm)};
            5'd16:   return {1'b1, i_fmt(6'h09, rs, rt, imm)};
            5'd17:   return {1'b1, i_fmt(6'h0c, rs, rt, imm)};
            5'd18:   return {1'b1, i_fmt(6'h0a, rs, rt, imm)};
            5'd19:   return {1'b1, i_fmt(6'h0b, rs, rt, imm)};
            5'd20:   return {1'b1, i_fmt(6'h0f, 5'd0, rt, imm)};
            5'd21:   return {1'b1, i_fmt(6'h23, rs, rt, imm)};
            5'd22:   return {1'b1, i_fmt(6'h2b, rs, rt, imm)};
            5'd23:   return {1'b1, i_fmt(6'h04, rs, rt, imm)};
            5'd24:   return {1'b1, 6'h02, tgt};
            5'd25:   return {1'b1, 6'h03, tgt};
            default: return 33'd0;
        endcase
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;
    logic                  in_ready_s;
    logic                  accept_s;
    logic [32:0]           enc_s;

    assign in_ready_s = (state_q == ST_RUN) && !clear;
    assign accept_s   = in_valid && in_ready_s;
    assign enc_s      = encode(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);

    // Next-state: clear rewinds everything; an accept either writes a word or flags an error.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        full_d      = full_q;
        err_d       = err_q;
        if (clear) begin
            state_d = ST_RUN;
            ptr_d   = BASE_PTR;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept_s) begin
            if (!enc_s[32]) begin
                err_d   = 1'b1;
                state_d = ST_ERROR;
            end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = ptr_q;
                mem_wdata_d = enc_s[31:0];
                count_d     = count_q + (ADDR_WIDTH + 1)'(1);
                // The top address is written once; the pointer parks there instead of wrapping.
                if (ptr_q == TOP_PTR) begin
                    full_d  = 1'b1;
                    state_d = ST_FULL;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset drops any pending write immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            ptr_q       <= BASE_PTR;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_PTR;
            mem_wdata_q <= 32'd0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = full_q;
    assign err       = err_q;

endmodule
